// File: rtl/led_scan_pkg.sv
// rtl/led_scan_pkg.sv - shared geometry, state and row types for the LED matrix scan capture
//
// Purpose: common definitions imported by scan_row_detector and led_matrix_scan_capture.
//   ROWS/COLS/PLANES : matrix geometry (8 rows, 8 columns, 3 colour planes)
//   state_t          : frame assembly state (HUNT waits for row 0, CAPTURE follows rows in order)
//   row_t            : 3-bit scan row index
//   pix_row_t        : one row of all planes, packed {A,B,C}, 1 = lit
package led_scan_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int PLANES = 3;

  typedef enum logic {HUNT, CAPTURE} state_t;

  typedef logic [2:0]              row_t;
  typedef logic [COLS*PLANES-1:0]  pix_row_t;

endpackage

// File: rtl/scan_row_detector.sv
// rtl/scan_row_detector.sv - synchronizes the scan bus and emits one sample per stable row dwell
//
// Purpose: brings the asynchronous scan bus into the CLK domain, measures how long the
// row index has been stable, and produces a single sample pulse once it has settled.
// Ports:
//   CLK, reset        : clock, synchronous active-high reset
//   scan_en           : scan bus enable (raw)
//   row_sel           : scan row (raw)
//   col_a_n/b_n/c_n   : active-low column planes (raw)
//   sample            : one-cycle pulse, row/cols valid while high
//   row               : row index of the sample
//   cols              : {A,B,C} of the sample, inverted so 1 = lit
//   stall             : level, row has dwelt TIMEOUT_CYCLES without changing
module scan_row_detector
  import led_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [2:0] row_sel,
  input  logic [7:0] col_a_n,
  input  logic [7:0] col_b_n,
  input  logic [7:0] col_c_n,
  output logic       sample,
  output row_t       row,
  output pix_row_t   cols,
  output logic       stall
);

  localparam int            DW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] TIMEOUT_MAX = DW'(TIMEOUT_CYCLES);

  logic          en_s1, en_s2;
  row_t          row_s1, row_s2;
  pix_row_t      cols_s1, cols_s2;
  logic [DW-1:0] dwell;
  logic          row_change;

  // Looking one stage ahead lets the dwell count restart on the same edge the
  // new row lands in row_s2, so dwell == k means row_s2 has held for k+1 cycles.
  assign row_change = (row_s1 != row_s2);

  always_ff @(posedge CLK) begin
    if (reset) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      row_s1  <= '0;
      row_s2  <= '0;
      cols_s1 <= '0;
      cols_s2 <= '0;
      dwell   <= '0;
      sample  <= 1'b0;
      row     <= '0;
      cols    <= '0;
      stall   <= 1'b0;
    end else begin
      en_s1   <= scan_en;
      en_s2   <= en_s1;
      row_s1  <= row_sel;
      row_s2  <= row_s1;
      cols_s1 <= {col_a_n, col_b_n, col_c_n};
      cols_s2 <= cols_s1;

      if (row_change) begin
        dwell <= '0;
      end else if (dwell != TIMEOUT_MAX) begin
        dwell <= dwell + DW'(1);
      end

      // row_s2 still holds the settled row on this edge even if a change is pending.
      sample <= en_s2 && (dwell == SETTLE_LAST);
      if (dwell == SETTLE_LAST) begin
        row  <= row_s2;
        cols <= ~cols_s2;
      end

      if (row_change) begin
        stall <= 1'b0;
      end else if (dwell == TIMEOUT_MAX) begin
        stall <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scan_capture.sv
// rtl/led_matrix_scan_capture.sv - rebuilds double-buffered 8x8x3 frames from a row-scanned LED bus
//
// Purpose: assembles samples from scan_row_detector into a shadow frame, commits it to the
// front buffer when row 7 completes an in-order scan, and exposes the front buffer.
// Optional feature macro: LED_SCAN_CAP_STABLE_EN (frame_stable after STABLE_FRAMES identical frames).
// Ports:
//   CLK, reset          : clock, synchronous active-high reset
//   scan_en, row_sel    : scan bus enable and row index
//   col_a_n/b_n/c_n     : active-low column planes
//   rd_row / rd_data    : front-buffer read port, {A,B,C} 1 = lit, one cycle latency
//   frame_done          : pulse the cycle after a frame commit
//   frame_count         : committed frames, wrapping
//   seq_err             : pulse on an out-of-order row
//   seq_err_count       : out-of-order rows, saturating at 255
//   scan_stall          : row dwell exceeded TIMEOUT_CYCLES
//   frame_stable        : identical-frame indicator (0 unless the feature is built in)
module led_matrix_scan_capture
  import led_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
`ifdef LED_SCAN_CAP_STABLE_EN
  ,
  parameter int STABLE_FRAMES  = 3
`endif
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [2:0]  row_sel,
  input  logic [7:0]  col_a_n,
  input  logic [7:0]  col_b_n,
  input  logic [7:0]  col_c_n,
  input  logic [2:0]  rd_row,
  output logic [23:0] rd_data,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        seq_err,
  output logic [7:0]  seq_err_count,
  output logic        scan_stall,
  output logic        frame_stable
);

  logic     det_sample;
  row_t     det_row;
  pix_row_t det_cols;
  logic     det_stall;

  scan_row_detector #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_detector (
    .CLK     (CLK),
    .reset   (reset),
    .scan_en (scan_en),
    .row_sel (row_sel),
    .col_a_n (col_a_n),
    .col_b_n (col_b_n),
    .col_c_n (col_c_n),
    .sample  (det_sample),
    .row     (det_row),
    .cols    (det_cols),
    .stall   (det_stall)
  );

  state_t   state_q, state_d;
  row_t     exp_row_q, exp_row_d;
  pix_row_t shadow [ROWS];
  pix_row_t front  [ROWS];
  pix_row_t new_frame [ROWS];
  logic     shadow_we;
  logic     commit;
  logic     seq_err_d;

  always_comb begin
    state_d   = state_q;
    exp_row_d = exp_row_q;
    shadow_we = 1'b0;
    commit    = 1'b0;
    seq_err_d = 1'b0;
    if (det_stall) begin
      state_d   = HUNT;
      exp_row_d = '0;
    end else if (det_sample) begin
      if (state_q == HUNT) begin
        if (det_row == 3'd0) begin
          shadow_we = 1'b1;
          exp_row_d = 3'd1;
          state_d   = CAPTURE;
        end
      end else if (det_row == exp_row_q) begin
        shadow_we = 1'b1;
        exp_row_d = det_row + 3'd1;
        commit    = (det_row == 3'd7);
      end else begin
        seq_err_d = 1'b1;
        if (det_row == 3'd0) begin
          shadow_we = 1'b1;
          exp_row_d = 3'd1;
        end else begin
          state_d   = HUNT;
          exp_row_d = '0;
        end
      end
    end
  end

  // Complete frame as it will look after this sample: shadow with the incoming row merged in.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      new_frame[r] = shadow[r];
    end
    new_frame[det_row] = det_cols;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= HUNT;
      exp_row_q     <= '0;
      for (int r = 0; r < ROWS; r++) begin
        shadow[r] <= '0;
        front[r]  <= '0;
      end
      rd_data       <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      seq_err       <= 1'b0;
      seq_err_count <= '0;
    end else begin
      state_q   <= state_d;
      exp_row_q <= exp_row_d;
      if (shadow_we) begin
        shadow[det_row] <= det_cols;
      end
      if (commit) begin
        for (int r = 0; r < ROWS; r++) begin
          front[r] <= new_frame[r];
        end
        frame_count <= frame_count + 16'd1;
      end
      // Reads the pre-commit front on the commit edge.
      rd_data    <= front[rd_row];
      frame_done <= commit;
      seq_err    <= seq_err_d;
      if (seq_err_d && (seq_err_count != 8'hFF)) begin
        seq_err_count <= seq_err_count + 8'd1;
      end
    end
  end

  assign scan_stall = det_stall;

`ifdef LED_SCAN_CAP_STABLE_EN
  logic [7:0] stable_cnt;
  logic [7:0] stable_cnt_d;
  logic       frame_match;

  always_comb begin
    frame_match = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      if (new_frame[r] != front[r]) begin
        frame_match = 1'b0;
      end
    end
    if (!frame_match) begin
      stable_cnt_d = 8'd1;
    end else if (stable_cnt == 8'hFF) begin
      stable_cnt_d = stable_cnt;
    end else begin
      stable_cnt_d = stable_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      stable_cnt   <= '0;
      frame_stable <= 1'b0;
    end else if (commit) begin
      stable_cnt   <= stable_cnt_d;
      frame_stable <= ({24'd0, stable_cnt_d} >= 32'(STABLE_FRAMES));
    end
  end
`else
  assign frame_stable = 1'b0;
`endif

endmodule

// File: tb/tb_led_matrix_scan_capture.sv
// tb/tb_led_matrix_scan_capture.sv - randomized self-checking bench for led_matrix_scan_capture
module tb_led_matrix_scan_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  logic        CLK = 1'b0;
  logic        reset;
  logic        scan_en;
  logic [2:0]  row_sel;
  logic [7:0]  col_a_n, col_b_n, col_c_n;
  logic [2:0]  rd_row;
  logic [23:0] rd_data;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        seq_err;
  logic [7:0]  seq_err_count;
  logic        scan_stall;
  logic        frame_stable;

  always #5 CLK = ~CLK;

  led_matrix_scan_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .scan_en       (scan_en),
    .row_sel       (row_sel),
    .col_a_n       (col_a_n),
    .col_b_n       (col_b_n),
    .col_c_n       (col_c_n),
    .rd_row        (rd_row),
    .rd_data       (rd_data),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .seq_err       (seq_err),
    .seq_err_count (seq_err_count),
    .scan_stall    (scan_stall),
    .frame_stable  (frame_stable)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame assembly by the row-order rules, frames held as arrays.
  logic [23:0] m_shadow [8];
  logic [23:0] m_front  [8];
  bit          m_hunt;
  int          m_exp;
  int          m_fc;
  int          m_sec;
  int          m_stable;
  int          m_done_total = 0;
  int          m_err_total  = 0;
  int          prev_row;

  int          n_done = 0;
  int          n_err  = 0;

  always @(negedge CLK) begin
    if (frame_done === 1'b1) n_done++;
    if (seq_err === 1'b1)    n_err++;
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_front[i]  = '0;
    end
    m_hunt   = 1'b1;
    m_exp    = 0;
    m_fc     = 0;
    m_sec    = 0;
    m_stable = 0;
  endtask

  task automatic model_sample(int r, logic [23:0] d);
    bit same;
    if (m_hunt) begin
      if (r == 0) begin
        m_shadow[0] = d;
        m_exp       = 1;
        m_hunt      = 1'b0;
      end
    end else if (r == m_exp) begin
      m_shadow[r] = d;
      if (r == 7) begin
        same = 1'b1;
        for (int i = 0; i < 8; i++) if (m_shadow[i] != m_front[i]) same = 1'b0;
        m_stable = same ? ((m_stable < 255) ? m_stable + 1 : 255) : 1;
        for (int i = 0; i < 8; i++) m_front[i] = m_shadow[i];
        m_fc = (m_fc + 1) % 65536;
        m_done_total++;
        m_exp = 0;
      end else begin
        m_exp = r + 1;
      end
    end else begin
      m_err_total++;
      if (m_sec < 255) m_sec++;
      if (r == 0) begin
        m_shadow[0] = d;
        m_exp       = 1;
      end else begin
        m_hunt = 1'b1;
      end
    end
  endtask

  // Holds one row on the bus for 'hold' cycles; called and returns at a negedge.
  // A row is sampled if held at least SETTLE cycles with enable high; a hold of
  // TIMEOUT+2 or more cycles stalls the scan and drops assembly back to hunting.
  task automatic drive(int r, logic [23:0] lit, int hold, bit en);
    if (r == prev_row) begin
      row_sel = 3'(r + 1);
      scan_en = 1'b0;
      {col_a_n, col_b_n, col_c_n} = 24'hFFFFFF;
      @(negedge CLK);
    end
    row_sel = 3'(r);
    {col_a_n, col_b_n, col_c_n} = ~lit;
    scan_en = en;
    if (en && hold >= SETTLE) model_sample(r, lit);
    if (hold >= TIMEOUT + 2) m_hunt = 1'b1;
    prev_row = r;
    repeat (hold) @(negedge CLK);
  endtask

  task automatic full_scan(logic [23:0] base, bit rnd);
    for (int r = 0; r < 8; r++) begin
      drive(r, rnd ? 24'($urandom) : (base ^ 24'(r * 24'h010101)), 10, 1'b1);
    end
  endtask

  function automatic logic exp_stable();
`ifdef LED_SCAN_CAP_STABLE_EN
    return (m_stable >= 3);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(string tag);
    drive((prev_row + 3) & 7, 24'($urandom), 12, 1'b0);
    check_eq({tag, "_frame_count"},   32'(frame_count),   32'(m_fc));
    check_eq({tag, "_seq_err_count"}, 32'(seq_err_count), 32'(m_sec));
    check_eq({tag, "_scan_stall"},    32'(scan_stall),    32'd0);
    check_eq({tag, "_done_pulses"},   32'(n_done),        32'(m_done_total));
    check_eq({tag, "_err_pulses"},    32'(n_err),         32'(m_err_total));
    check_eq({tag, "_frame_stable"},  32'(frame_stable),  32'(exp_stable()));
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      @(negedge CLK);
      check_eq($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'(m_front[r]));
    end
  endtask

  task automatic do_reset(string tag);
    reset   = 1'b1;
    row_sel = 3'd7;
    scan_en = 1'b0;
    {col_a_n, col_b_n, col_c_n} = 24'hFFFFFF;
    rd_row  = 3'd0;
    repeat (2) @(negedge CLK);
    check_eq({tag, "_rst_rd_data"},       32'(rd_data),       32'd0);
    check_eq({tag, "_rst_frame_done"},    32'(frame_done),    32'd0);
    check_eq({tag, "_rst_frame_count"},   32'(frame_count),   32'd0);
    check_eq({tag, "_rst_seq_err"},       32'(seq_err),       32'd0);
    check_eq({tag, "_rst_seq_err_count"}, 32'(seq_err_count), 32'd0);
    check_eq({tag, "_rst_scan_stall"},    32'(scan_stall),    32'd0);
    check_eq({tag, "_rst_frame_stable"},  32'(frame_stable),  32'd0);
    reset = 1'b0;
    model_reset();
    prev_row = -1;
    drive(7, 24'd0, 12, 1'b0);
  endtask

  initial begin
    int r, hold, sel;
    bit en;

    do_reset("t1");

    // 1: clean scan, plane A lights column r on row r
    for (int i = 0; i < 8; i++) drive(i, {8'(8'h01 << i), 16'h0000}, 10, 1'b1);
    check_all("t1");
    check_eq("t1_fc_const", 32'(frame_count), 32'd1);
    rd_row = 3'd3;
    @(negedge CLK);
    check_eq("t1_rd3_const", 32'(rd_data), 32'h080000);

    // 2: rows 0,1,2 then 5 aborts the frame, next full scan commits cleanly
    drive(0, 24'hABCDEF, 10, 1'b1);
    drive(1, 24'h123456, 10, 1'b1);
    drive(2, 24'h654321, 10, 1'b1);
    drive(5, 24'h00FF00, 10, 1'b1);
    check_all("t2a");
    check_eq("t2_sec_const", 32'(seq_err_count), 32'd1);
    full_scan(24'h3C3C3C, 1'b0);
    check_all("t2b");

    // 3: row glitch shorter than the settle window, plus a hold of exactly SETTLE
    drive(0, 24'h111111, 10, 1'b1);
    drive(1, 24'h222222, SETTLE, 1'b1);
    drive(2, 24'h333333, SETTLE - 2, 1'b1);
    drive(3, 24'h444444, 10, 1'b1);
    drive(4, 24'h555555, 10, 1'b1);
    check_all("t3");

    // 4: stall on a long dwell, recovery after a row change
    drive(4, 24'h0F0F0F, TIMEOUT + 5, 1'b1);
    check_eq("t4_stall_set", 32'(scan_stall), 32'd1);
    drive(5, 24'h000000, 10, 1'b0);
    check_eq("t4_stall_clr", 32'(scan_stall), 32'd0);
    full_scan(24'hA5005A, 1'b0);
    check_all("t4");

    // 5: reset in the middle of a frame
    for (int i = 0; i < 4; i++) drive(i, 24'($urandom), 10, 1'b1);
    do_reset("t5");
    check_all("t5a");
    full_scan(24'h0, 1'b1);
    check_all("t5b");
    check_eq("t5_fc_const", 32'(frame_count), 32'd1);

`ifdef LED_SCAN_CAP_STABLE_EN
    // 6: three identical frames then a changed one
    for (int f = 0; f < 3; f++) begin
      full_scan(24'h5AC3E7, 1'b0);
      check_all($sformatf("t6_f%0d", f));
    end
    check_eq("t6_stable_on", 32'(frame_stable), 32'd1);
    full_scan(24'h81C3FF, 1'b0);
    check_all("t6_f3");
    check_eq("t6_stable_off", 32'(frame_stable), 32'd0);
`endif

    // Random scans: mostly in-order rows with glitches, gaps, long dwells and disorder
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 40; i++) begin
        sel = $urandom_range(0, 99);
        r = (sel < 75) ? ((prev_row + 1) & 7) : $urandom_range(0, 7);
        sel = $urandom_range(0, 99);
        if (sel < 10)      hold = $urandom_range(1, SETTLE - 1);
        else if (sel < 14) hold = $urandom_range(TIMEOUT + 3, TIMEOUT + 8);
        else               hold = $urandom_range(SETTLE, 12);
        en = ($urandom_range(0, 9) != 0);
        drive(r, 24'($urandom), hold, en);
      end
      check_all($sformatf("rnd%0d", b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_capture.md
Name: led_matrix_scan_capture

Overview:
Receive-side counterpart of the game's row-scanned 8x8 LED matrix driver. It samples the multiplexed scan bus (row index, three active-low 8-bit column planes, enable) and rebuilds a full double-buffered 8x8x3 frame. Frames are exposed through a registered read port plus a frame-done pulse. It sits on the test/HIL board or a loopback path, so gameplay frames can be checked without a camera.

Parameters:
SETTLE_CYCLES, 4, cycles row_sel must stay stable before columns are sampled (1..255)
TIMEOUT_CYCLES, 200000, dwell cycles without a row change before stall is declared
STABLE_FRAMES, 3, identical consecutive frames needed for frame_stable (optional feature only)

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-high
scan_en  in  1  scan bus enable (driver's led[27])
row_sel  in  3  current scan row (driver's led[24:26])
col_a_n  in  8  plane A columns, active-low (led[0:7])
col_b_n  in  8  plane B columns, active-low (led[8:15])
col_c_n  in  8  plane C columns, active-low (led[16:23])
rd_row  in  3  front-buffer read row
rd_data  out  24  {A,B,C} of rd_row, 1 = lit, registered
frame_done  out  1  one-cycle pulse on frame commit
frame_count  out  16  committed frames, wraps at 0xFFFF->0
seq_err  out  1  one-cycle pulse on out-of-order row
seq_err_count  out  8  saturating at 255
scan_stall  out  1  level, dwell exceeded TIMEOUT_CYCLES
frame_stable  out  1  see Optional Feature

Behaviour:
- Reset (synchronous, active-high): clock CLK. All outputs 0, both buffers 0, FSM to HUNT, counters 0, sync flops 0.
- All scan inputs pass a 2-flop synchronizer. Column data is inverted on capture, so a stored 1 means lit.
- Dwell counter clears on any change of synced row_sel, otherwise increments and saturates at TIMEOUT_CYCLES.
- Sample event: one pulse per dwell, when dwell == SETTLE_CYCLES-1 and scan_en is high. With scan_en low, the dwell counter still runs but no sample is taken.
- Latency: pin to sample is 2 + SETTLE_CYCLES cycles.
- FSM HUNT: ignores sample events except row 0.
  - Row 0: write shadow[0], expect=1, go to CAPTURE.
- FSM CAPTURE, sample with row == expect:
  - Write shadow[row] and set expect=row+1 (mod 8).
  - If row == 7: copy shadow to front. frame_done pulses the cycle after the commit, and frame_count increments on that cycle. Stay in CAPTURE with expect=0.
- FSM CAPTURE, sample with row != expect:
  - Pulse seq_err and increment seq_err_count (saturating).
  - If row == 0: restart the frame (write shadow[0], expect=1).
  - Otherwise: go to HUNT.
  - The front buffer is never partially updated.
- Stall: when dwell reaches TIMEOUT_CYCLES, scan_stall is set and the FSM goes to HUNT. scan_stall clears on the cycle after the next row change.
- Read port: rd_data = front[rd_row], 1-cycle registered. On the commit cycle, old front data is returned (read-before-write).
- Reset mid-frame: the partial shadow is discarded and the front buffer is cleared.

Optional Feature:
Macro LED_SCAN_CAP_STABLE_EN.
- Defined: at commit, the shadow is compared with the old front. On a match the stable counter increments (saturating), on a mismatch it resets to 1. frame_stable = counter >= STABLE_FRAMES, updating with frame_done.
- Not defined: frame_stable tied 0, no comparator or counter logic.

Decomposition:
Package led_scan_pkg:
- ROWS=8, COLS=8, PLANES=3
- state enum {HUNT, CAPTURE}
- typedef row_t (3b) and pix_row_t (24b)

One sub-module, scan_row_detector, holds:
- synchronizer
- dwell counter
- sample pulse
- stall flag
It outputs sample, row, cols and stall.

Test Plan:
1. Clean scan, rows 0..7, each held 10 cycles, with row r driving col_a_n=~(1<<r) and B=C=0xFF -> one frame_done and frame_count=1; rd_row=3 gives rd_data=0x080000.
2. Rows 0,1,2,5 -> seq_err pulse on row 5, seq_err_count=1, FSM in HUNT. A following full 0..7 scan commits, and the front buffer holds no row-0..2 data from the aborted frame.
3. Row glitch: row held only SETTLE_CYCLES-2 cycles -> no sample for that row. The next row then raises seq_err, or is ignored in HUNT.
4. Hold row 4 for TIMEOUT_CYCLES+5 cycles (TIMEOUT_CYCLES=50 in bench) -> scan_stall=1. After a row change scan_stall=0, and a resumed 0..7 scan commits a frame.
5. Mid-frame reset after rows 0..3 -> all outputs 0, front buffer cleared. A subsequent full scan gives frame_count=1.
6. LED_SCAN_CAP_STABLE_EN defined, 3 identical frames then 1 changed frame -> frame_stable goes 1 on the 3rd frame_done and 0 on the 4th.
